// File: rtl/addsub_share_arbiter_if.sv
// Request/response bundle for addsub_share_arbiter: two requester channels plus one tagged result channel.
// master = requester/consumer side, slave = arbiter side.
interface addsub_share_arbiter_if #(
   parameter int n = 16
);
   logic         req0_valid;
   logic         req0_ready;
   logic [n-1:0] req0_x;
   logic [n-1:0] req0_y;
   logic         req0_add_n;
   logic         req1_valid;
   logic         req1_ready;
   logic [n-1:0] req1_x;
   logic [n-1:0] req1_y;
   logic         req1_add_n;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [n-1:0] rsp_s;
   logic         rsp_c_out;
   logic         rsp_overflow;

   modport master (
      output req0_valid, req0_x, req0_y, req0_add_n,
      output req1_valid, req1_x, req1_y, req1_add_n,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_s, rsp_c_out, rsp_overflow
   );

   modport slave (
      input  req0_valid, req0_x, req0_y, req0_add_n,
      input  req1_valid, req1_x, req1_y, req1_add_n,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_s, rsp_c_out, rsp_overflow
   );
endinterface

// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter sharing one adder_subtractor_nbit between two requesters, IDLE->EXEC->RESP per operation.
// Define ADDSUB_ARB_SAT_EN to clamp rsp_s on signed overflow instead of wrapping.
module adder_subtractor_nbit #(
   parameter int n = 16
) (
   input  logic [n-1:0] i_x,
   input  logic [n-1:0] i_y,
   input  logic         i_add_n,
   output logic [n-1:0] o_s,
   output logic         o_c_out,
   output logic         o_overflow
);
   logic [n-1:0] w_y_eff;
   logic [n:0]   w_sum;

   // Subtract as x + ~y + 1 so c_out reads as "no borrow".
   assign w_y_eff    = i_y ^ {n{i_add_n}};
   assign w_sum      = {1'b0, i_x} + {1'b0, w_y_eff} + {{n{1'b0}}, i_add_n};
   assign o_s        = w_sum[n-1:0];
   assign o_c_out    = w_sum[n];
   assign o_overflow = (i_x[n-1] == w_y_eff[n-1]) && (o_s[n-1] != i_x[n-1]);
endmodule

module addsub_share_arbiter #(
   parameter int n = 16
) (
   input logic                   clk,
   input logic                   reset_n,
   addsub_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t       r_state;
   logic         r_rr_last;
   logic [n-1:0] r_x;
   logic [n-1:0] r_y;
   logic         r_add_n;
   logic         r_id;
   logic         r_rsp_valid;
   logic         r_rsp_id;
   logic [n-1:0] r_rsp_s;
   logic         r_rsp_c_out;
   logic         r_rsp_ovf;

   logic         w_idle;
   logic         w_gnt0;
   logic         w_gnt1;
   logic [n-1:0] w_s;
   logic         w_c_out;
   logic         w_ovf;

`ifdef ADDSUB_ARB_SAT_EN
   // On overflow the true result's sign equals the sign of x.
   function automatic logic [n-1:0] f_sat(input logic [n-1:0] s, input logic ovf, input logic x_msb);
      if (!ovf)
         return s;
      return x_msb ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
   endfunction
`endif

   // Contention goes to the requester that did not win last time.
   assign w_idle = reset_n && (r_state == S_IDLE);
   assign w_gnt0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_rr_last);
   assign w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_rr_last);

   adder_subtractor_nbit #(.n(n)) u_addsub (
      .i_x        (r_x),
      .i_y        (r_y),
      .i_add_n    (r_add_n),
      .o_s        (w_s),
      .o_c_out    (w_c_out),
      .o_overflow (w_ovf)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_rr_last   <= 1'b1;
         r_x         <= '0;
         r_y         <= '0;
         r_add_n     <= 1'b0;
         r_id        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_s     <= '0;
         r_rsp_c_out <= 1'b0;
         r_rsp_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt0) begin
                  r_x       <= bus.req0_x;
                  r_y       <= bus.req0_y;
                  r_add_n   <= bus.req0_add_n;
                  r_id      <= 1'b0;
                  r_rr_last <= 1'b0;
                  r_state   <= S_EXEC;
               end else if (w_gnt1) begin
                  r_x       <= bus.req1_x;
                  r_y       <= bus.req1_y;
                  r_add_n   <= bus.req1_add_n;
                  r_id      <= 1'b1;
                  r_rr_last <= 1'b1;
                  r_state   <= S_EXEC;
               end
            end
            S_EXEC: begin
`ifdef ADDSUB_ARB_SAT_EN
               r_rsp_s     <= f_sat(w_s, w_ovf, r_x[n-1]);
`else
               r_rsp_s     <= w_s;
`endif
               r_rsp_c_out <= w_c_out;
               r_rsp_ovf   <= w_ovf;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req0_ready   = w_gnt0;
   assign bus.req1_ready   = w_gnt1;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_id       = r_rsp_id;
   assign bus.rsp_s        = r_rsp_s;
   assign bus.rsp_c_out    = r_rsp_c_out;
   assign bus.rsp_overflow = r_rsp_ovf;
endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Self-checking bench for addsub_share_arbiter: directed cases plus randomized traffic against a transaction-level model.
module tb_addsub_share_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   addsub_share_arbiter_if #(.n(16)) bus ();

   addsub_share_arbiter #(.n(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct {
      logic        id;
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   int   m_busy   = 0;
   int   m_phase  = 0;
   int   m_last   = 1;
   exp_t m_q[$];
   int   last_gnt;
   logic        smp_valid;
   logic        smp_id;
   logic [15:0] smp_s;
   logic        smp_c;
   logic        smp_o;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected result from plain integer arithmetic on the operands.
   function automatic exp_t model_op(input logic id, input logic [15:0] x, input logic [15:0] y, input logic sub);
      exp_t e;
      int ux, uy, sx, sy, ur, sr;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (sub) begin
         ur  = ux - uy;
         sr  = sx - sy;
         e.c = (ux >= uy);
      end else begin
         ur  = ux + uy;
         sr  = sx + sy;
         e.c = (ur > 65535);
      end
      e.s  = 16'(ur);
      e.o  = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_ARB_SAT_EN
      if (e.o) e.s = (sr < 0) ? 16'h8000 : 16'h7FFF;
`endif
      e.id = id;
      return e;
   endfunction

   // One clock: check outputs mid-cycle, then advance the model across the rising edge.
   task automatic step();
      int   g;
      logic rdy;
      exp_t e;
      #1;
      g = -1;
      if (m_busy == 0) begin
         if (bus.req0_valid && bus.req1_valid) g = (m_last == 1) ? 0 : 1;
         else if (bus.req0_valid)              g = 0;
         else if (bus.req1_valid)              g = 1;
      end
      chk("req0_ready", {31'b0, bus.req0_ready}, {31'b0, g == 0});
      chk("req1_ready", {31'b0, bus.req1_ready}, {31'b0, g == 1});
      chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, (m_busy != 0) && (m_phase == 2)});
      smp_valid = bus.rsp_valid;
      smp_id    = bus.rsp_id;
      smp_s     = bus.rsp_s;
      smp_c     = bus.rsp_c_out;
      smp_o     = bus.rsp_overflow;
      if (m_busy != 0 && m_phase == 2 && m_q.size() > 0) begin
         chk("rsp_id", {31'b0, bus.rsp_id}, {31'b0, m_q[0].id});
         chk("rsp_s", {16'b0, bus.rsp_s}, {16'b0, m_q[0].s});
         chk("rsp_c_out", {31'b0, bus.rsp_c_out}, {31'b0, m_q[0].c});
         chk("rsp_overflow", {31'b0, bus.rsp_overflow}, {31'b0, m_q[0].o});
      end
      if (g == 0) e = model_op(1'b0, bus.req0_x, bus.req0_y, bus.req0_add_n);
      else        e = model_op(1'b1, bus.req1_x, bus.req1_y, bus.req1_add_n);
      rdy      = bus.rsp_ready;
      last_gnt = g;
      @(posedge clk);
      if (g >= 0) begin
         m_q.push_back(e);
         m_busy  = 1;
         m_phase = 1;
         m_last  = g;
      end else if (m_busy != 0 && m_phase == 1) begin
         m_phase = 2;
      end else if (m_busy != 0 && m_phase == 2 && rdy) begin
         void'(m_q.pop_front());
         m_busy = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; i < 8 && m_busy != 0; i++) step();
      chk("drain_idle", m_busy, 0);
   endtask

   task automatic run_one(input int k, input logic [15:0] x, input logic [15:0] y, input logic sub,
                          input logic [15:0] es, input logic ec, input logic eo);
      int granted, seen;
      idle_inputs();
      bus.req0_x = x; bus.req0_y = y; bus.req0_add_n = sub;
      bus.req1_x = x; bus.req1_y = y; bus.req1_add_n = sub;
      if (k == 0) bus.req0_valid = 1'b1;
      else        bus.req1_valid = 1'b1;
      granted = 0;
      for (int i = 0; i < 8 && granted == 0; i++) begin
         step();
         if (last_gnt == k) granted = 1;
      end
      idle_inputs();
      if (granted == 0) chk("grant_timeout", 0, 1);
      seen = 0;
      for (int i = 0; i < 6 && seen == 0; i++) begin
         step();
         if (smp_valid) seen = 1;
      end
      if (seen == 0) begin
         chk("rsp_timeout", 0, 1);
      end else begin
         chk("lit_id", {31'b0, smp_id}, k);
         chk("lit_s", {16'b0, smp_s}, {16'b0, es});
         chk("lit_c_out", {31'b0, smp_c}, {31'b0, ec});
         chk("lit_overflow", {31'b0, smp_o}, {31'b0, eo});
      end
   endtask

   function automatic logic [15:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         4: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int ngnt;
      int nprev;
      reset_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_add_n = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_add_n = 1'b0;
      bus.rsp_ready  = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
      chk("rst_rsp_id", {31'b0, bus.rsp_id}, 0);
      chk("rst_rsp_s", {16'b0, bus.rsp_s}, 0);
      chk("rst_rsp_c_out", {31'b0, bus.rsp_c_out}, 0);
      chk("rst_rsp_overflow", {31'b0, bus.rsp_overflow}, 0);
      chk("rst_req0_ready", {31'b0, bus.req0_ready}, 0);
      chk("rst_req1_ready", {31'b0, bus.req1_ready}, 0);
      reset_n = 1'b1;

      run_one(0, 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
      run_one(1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one(1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
`ifdef ADDSUB_ARB_SAT_EN
      run_one(0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      run_one(1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
      run_one(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

      // Both requesters permanently valid: grants alternate, one every 3 cycles.
      bus.rsp_ready = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      ngnt = 0;
      nprev = 1;
      for (int i = 0; i < 12; i++) begin
         bus.req0_x = pick_operand(); bus.req0_y = pick_operand(); bus.req0_add_n = 1'($urandom);
         bus.req1_x = pick_operand(); bus.req1_y = pick_operand(); bus.req1_add_n = 1'($urandom);
         step();
         if (last_gnt >= 0) begin
            chk("rr_alternate", last_gnt, 1 - nprev);
            nprev = last_gnt;
            ngnt++;
         end
      end
      chk("rr_count", ngnt, 4);
      drain();

      // Backpressure with requester 1 waiting behind a stalled result.
      bus.req0_x = 16'h1234; bus.req0_y = 16'h4321; bus.req0_add_n = 1'b0;
      bus.req1_x = 16'h0100; bus.req1_y = 16'h0001; bus.req1_add_n = 1'b1;
      bus.rsp_ready  = 1'b0;
      bus.req0_valid = 1'b1;
      step();
      chk("bp_gnt0", last_gnt, 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) step();
      bus.rsp_ready = 1'b1;
      step();
      step();
      chk("bp_gnt1", last_gnt, 1);
      drain();

      // Asynchronous reset while the operation is in EXEC.
      bus.req0_valid = 1'b1;
      step();
      chk("mid_gnt0", last_gnt, 0);
      bus.req0_valid = 1'b0;
      reset_n = 1'b0;
      m_busy = 0; m_phase = 0; m_last = 1; m_q.delete();
      #1;
      chk("mid_rst_valid_now", {31'b0, bus.rsp_valid}, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_valid_hold", {31'b0, bus.rsp_valid}, 0);
      chk("mid_rst_s", {16'b0, bus.rsp_s}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      step();
      chk("mid_rst_rr", last_gnt, 0);
      drain();

      // Random traffic: requesters come and go, consumer stalls at random.
      for (int i = 0; i < 400; i++) begin
         bus.req0_valid = ($urandom_range(0, 3) != 0);
         bus.req1_valid = ($urandom_range(0, 2) != 0);
         bus.req0_x = pick_operand(); bus.req0_y = pick_operand(); bus.req0_add_n = 1'($urandom);
         bus.req1_x = pick_operand(); bus.req1_y = pick_operand(); bus.req1_add_n = 1'($urandom);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/addsub_share_arbiter.md
Name: addsub_share_arbiter

Overview:
- Shares one adder_subtractor_nbit instance between two independent requesters, each with a valid/ready handshake.
- Grants by round-robin, latches the winner's operands and sequences the operation through the datapath.
- Presents a registered result, tagged with the requester id, on a single valid/ready response channel.
- Sits between two control sequencers and the shared arithmetic unit.

Parameters:
- n, 16, operand/result width in bits; passed through to the internal adder_subtractor_nbit.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_x  input  n  requester 0 operand x.
- req0_y  input  n  requester 0 operand y.
- req0_add_n  input  1  requester 0 op select: 0 = x+y, 1 = x-y.
- req1_valid, req1_ready, req1_x, req1_y, req1_add_n: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that issued the result.
- rsp_s  output  n  sum/difference.
- rsp_c_out  output  1  adder carry-out; for subtract, 1 = no borrow (x >= y unsigned).
- rsp_overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; rr_last=1, so requester 0 wins first.
  - Operand registers cleared.
  - rsp_valid=0, rsp_id=0, rsp_s=0, rsp_c_out=0, rsp_overflow=0; req0_ready=req1_ready=0.
- FSM states:
  - IDLE: any reqN_valid=1 -> grant, go EXEC.
  - EXEC: capture adder outputs into rsp registers, go RESP.
  - RESP: rsp_valid=1; on rsp_ready=1 go IDLE.
- Grant: only in IDLE.
  - One valid: that requester wins.
  - Both valid: the requester not equal to rr_last wins.
  - On grant: reqK_ready=1 for exactly that cycle (combinational from state and valids); x, y, add_n and id are latched; rr_last<=K.
  - rr_last changes only on a grant.
- Ready rules: req ready is never asserted outside IDLE, and never to both requesters at once.
- Datapath: latched operands drive the adder_subtractor_nbit instance; in EXEC its s, c_out and overflow are registered unchanged.
- Latency: grant at edge T; rsp_valid=1 after edge T+2.
  - Minimum spacing between grants is 3 cycles, with rsp_ready held high.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable and no new grant occurs.
- rsp_valid deasserts on the edge following the rsp_valid&rsp_ready handshake.
- A requester may drop valid before grant; no grant is issued to it.
- Widths: all arithmetic is modulo 2^n; no sign extension.
- Reset mid-operation (EXEC or RESP):
  - Pending result is discarded; rsp_valid=0 immediately.
  - FSM returns to IDLE; rr_last returns to 1.

Optional Feature:
- Macro: ADDSUB_ARB_SAT_EN.
- Defined: when the registered overflow=1, rsp_s is clamped instead of wrapped.
  - 0x7FF..F if the true result is positive, i.e. operand x MSB=0.
  - 0x800..0 if negative, i.e. x MSB=1.
  - rsp_overflow still reports 1; rsp_c_out is unchanged.
- Undefined: rsp_s is the wrapped adder result.
- Latency and handshake are identical in both builds.

Test Plan (n=16):
- Add, requester 0: req0 x=0x0003 y=0x0005 add_n=0 -> req0_ready 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, s=0x0008, c_out=0, overflow=0.
- Subtract, requester 1:
  - req1 x=0x0005 y=0x0007 add_n=1 -> s=0xFFFE, c_out=0, overflow=0, id=1.
  - Then x=0x0007 y=0x0005 -> s=0x0002, c_out=1.
- Round-robin: both valid continuously from reset, rsp_ready=1 -> grants and rsp_id sequence 0,1,0,1; each requester accepted every 6 cycles.
- Overflow:
  - 0x7FFF+0x0001 -> overflow=1, s=0x8000 (0x7FFF with ADDSUB_ARB_SAT_EN).
  - 0x8000-0x0001 -> overflow=1, c_out=1, s=0x7FFF (0x8000 with SAT_EN).
- Backpressure: result pending, rsp_ready=0 for 5 cycles, req1_valid=1 -> rsp_* stable, req1_ready=0 throughout; rsp_ready=1 -> req1 granted the cycle after rsp_valid falls.
- Reset mid-op: assert reset_n=0 during EXEC -> rsp_valid=0 immediately with no result emitted; after release, req0 wins when both requesters are valid.
